// File: rtl/shifter_seq.sv
// Multi-cycle barrel-free shifter: SLL/SRL/SRA/ROL by a runtime amount,
// advancing at most STEP bit positions per clock behind a start/ready/valid handshake.
//
// state | meaning
// IDLE  | no result held, ready for a request
// BUSY  | shifting, rem positions still to go
// DONE  | data_o holds the last result, ready for a request
module shifter_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic               abort_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    // one extra bit so STEP == WIDTH and the rotate complement both fit
    localparam logic [SHAMT_W:0] STEP_V  = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_V = (SHAMT_W+1)'(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] rem;
    logic [1:0]         mode;

    logic [SHAMT_W:0]   step;
    logic [WIDTH-1:0]   work_nxt;
    logic [SHAMT_W-1:0] rem_nxt;

    always_comb begin
        step = ({1'b0, rem} > STEP_V) ? STEP_V : {1'b0, rem};
        rem_nxt = SHAMT_W'({1'b0, rem} - step);
        work_nxt = work;
        case (mode)
            MODE_SLL: work_nxt = work << step;
            MODE_SRL: work_nxt = work >> step;
            // sign replication each step equals filling with the original MSB
            MODE_SRA: work_nxt = $signed(work) >>> step;
            MODE_ROL: work_nxt = (work << step) | (work >> (WIDTH_V - step));
            default:  work_nxt = work;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            work   <= '0;
            rem    <= '0;
            mode   <= '0;
            data_o <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        work <= data_i;
                        rem  <= shamt_i;
                        mode <= mode_i;
                        if (shamt_i == '0) begin
                            data_o <= data_i;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else begin
                        work <= work_nxt;
                        rem  <= rem_nxt;
                        if (rem_nxt == '0) begin
                            data_o <= work_nxt;
                            state  <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = (state != BUSY);
    assign valid_o = (state == DONE);

endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq (WIDTH=32, STEP=4): latency, results per mode,
// ignored starts, abort and asynchronous reset.
module tb_shifter_seq;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [4:0]  shamt_i;
    logic [31:0] data_i;
    logic        abort_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;

    int total;
    int bad;

    shifter_seq #(.WIDTH(32), .STEP(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .shamt_i (shamt_i),
        .data_i  (data_i),
        .abort_i (abort_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // called at a negedge; returns at the negedge after the accept edge
    task automatic start_op(input logic [1:0] m, input logic [4:0] sh, input logic [31:0] d);
        start_i = 1'b1;
        mode_i  = m;
        shamt_i = sh;
        data_i  = d;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        mode_i  = 2'b00;
        shamt_i = 5'd0;
        data_i  = 32'hDEAD_BEEF;
    endtask

    // counts edges after the accept edge until valid_o, bounded
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!valid_o && edges < 100) begin
            @(negedge clk_i);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        start_i = 1'b0; abort_i = 1'b0; mode_i = 2'b00; shamt_i = 5'd0; data_i = 32'h0;
        repeat (2) @(negedge clk_i);
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", data_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_sll();
        int e;
        start_op(2'b00, 5'd2, 32'h0000_0001);
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL sll_busy_ready got=%b want=0", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL sll_busy_valid got=%b want=0", valid_o); end
        wait_valid(e);
        total++; if (e !== 1) begin bad++; $display("FAIL sll_latency got=%0d want=1", e); end
        total++; if (data_o !== 32'h0000_0004) begin bad++; $display("FAIL sll_data got=%h want=00000004", data_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL sll_done_ready got=%b want=1", ready_o); end
    endtask

    task automatic test_sra_srl();
        int e;
        start_op(2'b10, 5'd31, 32'h8000_0000);
        wait_valid(e);
        total++; if (e !== 8) begin bad++; $display("FAIL sra31_latency got=%0d want=8", e); end
        total++; if (data_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sra31_data got=%h want=ffffffff", data_o); end
        start_op(2'b01, 5'd31, 32'h8000_0000);
        wait_valid(e);
        total++; if (e !== 8) begin bad++; $display("FAIL srl31_latency got=%0d want=8", e); end
        total++; if (data_o !== 32'h0000_0001) begin bad++; $display("FAIL srl31_data got=%h want=00000001", data_o); end
    endtask

    task automatic test_rol_srl();
        int e;
        start_op(2'b11, 5'd4, 32'h8000_0001);
        wait_valid(e);
        total++; if (e !== 1) begin bad++; $display("FAIL rol4_latency got=%0d want=1", e); end
        total++; if (data_o !== 32'h0000_0018) begin bad++; $display("FAIL rol4_data got=%h want=00000018", data_o); end
        start_op(2'b01, 5'd13, 32'h1234_5678);
        wait_valid(e);
        total++; if (e !== 4) begin bad++; $display("FAIL srl13_latency got=%0d want=4", e); end
        total++; if (data_o !== 32'h0000_91A2) begin bad++; $display("FAIL srl13_data got=%h want=000091a2", data_o); end
    endtask

    task automatic test_back_to_back();
        int e;
        start_op(2'b01, 5'd0, 32'hF000_0000);
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b want=1", valid_o); end
        total++; if (data_o !== 32'hF000_0000) begin bad++; $display("FAIL zero_data got=%h want=f0000000", data_o); end
        start_op(2'b00, 5'd8, 32'h0000_0001);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop got=%b want=0", valid_o); end
        wait_valid(e);
        total++; if (e !== 2) begin bad++; $display("FAIL b2b_latency got=%0d want=2", e); end
        total++; if (data_o !== 32'h0000_0100) begin bad++; $display("FAIL b2b_data got=%h want=00000100", data_o); end
    endtask

    task automatic test_ignore_abort();
        int e;
        start_op(2'b10, 5'd31, 32'h8000_0000);
        @(negedge clk_i);
        start_i = 1'b1; mode_i = 2'b00; shamt_i = 5'd1; data_i = 32'h0000_0001;
        @(posedge clk_i);
        @(negedge clk_i);
        mode_i = 2'b11; shamt_i = 5'd0; data_i = 32'h5555_5555;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL ignore_still_busy got=%b want=0", ready_o); end
        wait_valid(e);
        total++; if (e + 3 !== 8) begin bad++; $display("FAIL ignore_latency got=%0d want=8", e + 3); end
        total++; if (data_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ignore_data got=%h want=ffffffff", data_o); end

        start_op(2'b00, 5'd20, 32'h0000_0001);
        repeat (2) @(negedge clk_i);
        abort_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        abort_i = 1'b0;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", valid_o); end
        total++; if (data_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL abort_data got=%h want=ffffffff", data_o); end
        repeat (4) @(negedge clk_i);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL abort_stays_idle got=%b want=0", valid_o); end
    endtask

    task automatic test_async_reset();
        int e;
        start_op(2'b00, 5'd16, 32'h0000_0003);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", valid_o); end
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL arst_data got=%h want=00000000", data_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        start_op(2'b11, 5'd4, 32'h8000_0001);
        wait_valid(e);
        total++; if (e !== 1) begin bad++; $display("FAIL post_rst_latency got=%0d want=1", e); end
        total++; if (data_o !== 32'h0000_0018) begin bad++; $display("FAIL post_rst_data got=%h want=00000018", data_o); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_sll();
        test_sra_srl();
        test_rol_srl();
        test_back_to_back();
        test_ignore_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
